sipo_frame_controller: RTL and testbench



---
 rtl/sipo_ctrl_pkg.sv | 13 +
 rtl/sipo_shift_core.sv | 39 +++
 rtl/sipo_frame_controller.sv | 131 +++++++++++++
 tb/tb_sipo_frame_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the SIPO frame controller: FSM states and defaults.
package sipo_ctrl_pkg;

   localparam int STATE_W       = 2;
   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in shifter; new bits enter at the top and move toward bit 0,
// so the first bit received ends up in bit 0 after WIDTH shifts.
module sipo_shift_core #(
   parameter int WIDTH = sipo_ctrl_pkg::DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] shift_next;

   // Each bit takes its upper neighbour; the top bit takes the serial input.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign shift_next[gi] = q_reg[gi+1];
      end
   endgenerate
   assign shift_next[WIDTH-1] = in;

   // Shift register: clear has priority over a shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_reg <= '0;
      end else if (clr) begin
         q_reg <= '0;
      end else if (en) begin
         q_reg <= shift_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/sipo_frame_controller.sv
// Frame controller: counts WIDTH qualified serial bits after a start pulse,
// then moves the assembled word into a valid/ready holding register and
// flags words lost while the consumer stalls.
module sipo_frame_controller
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             in,
   input  logic             bit_en,
   input  logic             ready,
   input  logic             clr_overrun,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             busy,
   output logic             overrun
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [WIDTH-1:0] data_reg;
   logic             valid_reg;
   logic             overrun_reg;

   logic [WIDTH-1:0] shifter;
   logic             shift_clr;
   logic             shift_en;
   logic             slot_free;
   logic             load_word;
   logic             drop_word;

   sipo_shift_core #(.WIDTH(WIDTH)) u_shift (
      .clk   (clk),
      .reset (reset),
      .clr   (shift_clr),
      .en    (shift_en),
      .in    (in),
      .q     (shifter)
   );

   // Next-state, counter and shifter controls; defaults hold everything.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      shift_clr  = 1'b0;
      shift_en   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
               count_next = '0;
               shift_clr  = 1'b1;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_next = IDLE;
               count_next = '0;
            end else if (bit_en) begin
               shift_en = 1'b1;
               if (count_reg == LAST_CNT) begin
                  state_next = LOAD;
                  count_next = '0;
               end else begin
                  count_next = count_reg + CNT_W'(1);
               end
            end
         end
         LOAD: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   // The holding register is free if empty or being consumed this cycle.
   assign slot_free = !valid_reg || ready;
   assign load_word = (state_reg == LOAD) && slot_free;
   assign drop_word = (state_reg == LOAD) && !slot_free;

   // FSM state and bit counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   // Holding register and valid flag: a load wins over a consume.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (load_word) begin
         data_reg  <= shifter;
         valid_reg <= 1'b1;
      end else if (valid_reg && ready) begin
         valid_reg <= 1'b0;
      end
   end

   // Sticky overrun flag: a drop in the same cycle as a clear leaves it set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_reg <= 1'b0;
      end else if (drop_word) begin
         overrun_reg <= 1'b1;
      end else if (clr_overrun) begin
         overrun_reg <= 1'b0;
      end
   end

   assign data_out = data_reg;
   assign valid    = valid_reg;
   assign overrun  = overrun_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Directed bench for sipo_frame_controller (WIDTH=4).
module tb_sipo_frame_controller;

   logic       clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic       in;
   logic       bit_en;
   logic       ready;
   logic       clr_overrun;
   logic [3:0] data_out;
   logic       valid;
   logic       busy;
   logic       overrun;

   int pass_cnt  = 0;
   int total_cnt = 0;

   sipo_frame_controller #(.WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .in          (in),
      .bit_en      (bit_en),
      .ready       (ready),
      .clr_overrun (clr_overrun),
      .data_out    (data_out),
      .valid       (valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start pulse then four bits, bits[0] first; gap idle cycles between bits.
   // Returns with the controller in its LOAD cycle.
   task automatic frame(input logic [3:0] bits, input int gap);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bit_en = 1'b1;
         in     = bits[i];
         tick();
         bit_en = 1'b0;
         in     = 1'b0;
         if (i < 3) repeat (gap) tick();
      end
      $display("frame sent bits(first..last)=%b%b%b%b gap=%0d", bits[0], bits[1], bits[2], bits[3], gap);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; in = 1'b0;
      bit_en = 1'b0; ready = 1'b0; clr_overrun = 1'b0;
      tick(); tick();
      chk("rst_data", data_out, 4'h0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      reset = 1'b0;

      // Reset mid-frame
      start = 1'b1; tick(); start = 1'b0;
      chk("mid_busy_before", busy, 1'b1);
      bit_en = 1'b1; in = 1'b1; tick(); tick(); bit_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", valid, 1'b0);
      chk("mid_rst_data", data_out, 4'h0);
      reset = 1'b0;
      tick();
      ready = 1'b1;
      frame(4'b1010, 0);    // bits 0,1,0,1
      tick();
      $display("txn post-reset frame data_out=%b valid=%b", data_out, valid);
      chk("fresh_data", data_out, 4'b1010);
      chk("fresh_valid", valid, 1'b1);
      tick();
      chk("fresh_consumed", valid, 1'b0);

      // Basic frame 1,1,0,1
      frame(4'b1011, 0);
      chk("basic_load_busy", busy, 1'b1);
      chk("basic_load_valid", valid, 1'b0);
      tick();
      $display("txn basic data_out=%b valid=%b", data_out, valid);
      chk("basic_data", data_out, 4'b1011);
      chk("basic_valid", valid, 1'b1);
      chk("basic_busy", busy, 1'b0);
      tick();
      chk("basic_drop_valid", valid, 1'b0);
      chk("basic_hold_data", data_out, 4'b1011);

      // Gapped strobes 0,1,1,0
      frame(4'b0110, 3);
      tick();
      $display("txn gapped data_out=%b valid=%b", data_out, valid);
      chk("gap_data", data_out, 4'b0110);
      chk("gap_valid", valid, 1'b1);
      tick();

      // Abort after two bits, then frame 1,0,0,0
      start = 1'b1; tick(); start = 1'b0;
      bit_en = 1'b1; in = 1'b1; tick(); tick(); bit_en = 1'b0; in = 1'b0;
      abort = 1'b1; tick(); abort = 1'b0;
      $display("txn abort busy=%b valid=%b", busy, valid);
      chk("abort_busy", busy, 1'b0);
      chk("abort_valid", valid, 1'b0);
      chk("abort_data", data_out, 4'b0110);
      frame(4'b0001, 0);
      tick();
      $display("txn after-abort data_out=%b valid=%b", data_out, valid);
      chk("abort_next_data", data_out, 4'b0001);
      chk("abort_next_valid", valid, 1'b1);
      tick();

      // Overrun
      ready = 1'b0;
      frame(4'b0101, 0);    // bits 1,0,1,0
      tick();
      chk("ovr_first_data", data_out, 4'b0101);
      chk("ovr_first_flag", overrun, 1'b0);
      frame(4'b1111, 0);
      tick();
      $display("txn overrun data_out=%b valid=%b overrun=%b", data_out, valid, overrun);
      chk("ovr_hold_data", data_out, 4'b0101);
      chk("ovr_valid", valid, 1'b1);
      chk("ovr_set", overrun, 1'b1);
      tick();
      chk("ovr_sticky", overrun, 1'b1);
      clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
      chk("ovr_cleared", overrun, 1'b0);
      frame(4'b1111, 0);
      clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
      $display("txn overrun-vs-clear overrun=%b", overrun);
      chk("ovr_set_wins", overrun, 1'b1);
      chk("ovr_data_stable", data_out, 4'b0101);
      clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;

      // LOAD with simultaneous consume
      ready = 1'b1; tick(); ready = 1'b0;
      chk("drain_valid", valid, 1'b0);
      frame(4'b0011, 0);    // bits 1,1,0,0
      tick();
      chk("hold_0011", data_out, 4'b0011);
      frame(4'b1100, 0);    // bits 0,0,1,1
      ready = 1'b1; start = 1'b1; bit_en = 1'b1; in = 1'b1;
      tick();
      start = 1'b0; bit_en = 1'b0; in = 1'b0;
      $display("txn load+consume data_out=%b valid=%b busy=%b", data_out, valid, busy);
      chk("swap_data", data_out, 4'b1100);
      chk("swap_valid", valid, 1'b1);
      chk("swap_busy", busy, 1'b0);
      chk("swap_no_ovr", overrun, 1'b0);
      tick();
      chk("swap_consumed", valid, 1'b0);
      chk("swap_start_ignored", busy, 1'b0);
      ready = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
